// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - 32-cycle shift-and-add multiplier with optional multiply-accumulate
//
// Optional feature macro: MUL_UNIT_MLA_EN
//   defined   : product starts at acc when accumulate=1 (MLA), else 0 (MUL)
//   undefined : acc and accumulate are ignored, product always starts at 0
//
// Ports:
//   clk        in   sole clock, all state on posedge
//   reset      in   synchronous active-high reset
//   start      in   request a multiply, accepted only in IDLE
//   a          in   [31:0] multiplicand
//   b          in   [31:0] multiplier
//   acc        in   [31:0] accumulate addend
//   accumulate in   1 = MLA, 0 = MUL
//   wa_in      in   [3:0] destination register index
//   busy       out  operation in flight (BUSY or DONE)
//   done       out  one-cycle result-valid / register-file write enable
//   result     out  [31:0] low 32 bits of product (+ addend)
//   wa_out     out  [3:0] latched destination index
//   flag_n     out  result[31]
//   flag_z     out  result == 0
module mul_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] acc,
    input  logic        accumulate,
    input  logic [3:0]  wa_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [3:0]  wa_out,
    output logic        flag_n,
    output logic        flag_z
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] product_q;
    logic [4:0]  cnt_q;
    logic [3:0]  wa_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] result_q;
    logic [3:0]  wa_out_q;
    logic        flag_n_q;
    logic        flag_z_q;

    logic [31:0] init_product_d;
    logic [31:0] product_d;
    logic [4:0]  cnt_d;

`ifdef MUL_UNIT_MLA_EN
    always_comb begin
        init_product_d = accumulate ? acc : 32'd0;
    end
`else
    logic unused_mla;
    assign unused_mla = ^{acc, accumulate};

    always_comb begin
        init_product_d = 32'd0;
    end
`endif

    // One partial product per BUSY cycle; carries past bit 31 are dropped.
    always_comb begin
        product_d = product_q + (mplier_q[0] ? mcand_q : 32'd0);
        cnt_d     = cnt_q + 5'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            wa_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            wa_out_q  <= '0;
            flag_n_q  <= 1'b0;
            flag_z_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mcand_q   <= a;
                        mplier_q  <= b;
                        wa_q      <= wa_in;
                        product_q <= init_product_d;
                        cnt_q     <= 5'd0;
                        busy_q    <= 1'b1;
                        state_q   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    product_q <= product_d;
                    mcand_q   <= mcand_q << 1;
                    mplier_q  <= mplier_q >> 1;
                    cnt_q     <= cnt_d;
                    // Counter wraps 31 -> 0 on the 32nd BUSY edge.
                    if (cnt_q == 5'd31) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Outputs are registered here and held until the next DONE.
                    result_q <= product_q;
                    flag_n_q <= product_q[31];
                    flag_z_q <= (product_q == 32'd0);
                    wa_out_q <= wa_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign wa_out = wa_out_q;
    assign flag_n = flag_n_q;
    assign flag_z = flag_z_q;

endmodule

// File: tb/tb_mul_unit.sv
// tb/tb_mul_unit.sv - self-checking bench for mul_unit against an arithmetic reference model
module tb_mul_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc;
    logic        accumulate;
    logic [3:0]  wa_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  wa_out;
    logic        flag_n;
    logic        flag_z;

    int errors = 0;
    int checks = 0;

    mul_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .acc        (acc),
        .accumulate (accumulate),
        .wa_in      (wa_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .wa_out     (wa_out),
        .flag_n     (flag_n),
        .flag_z     (flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [31:0] macc, input logic maccum);
        logic [63:0] p;
        logic [63:0] addend;
        p = {32'd0, ma} * {32'd0, mb};
        addend = 64'd0;
`ifdef MUL_UNIT_MLA_EN
        if (maccum) addend = {32'd0, macc};
`endif
        p = p + addend;
        return p[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one start pulse, scrambles inputs while busy, and checks latency,
    // busy continuity, result, destination, flags and pulse width.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic [31:0] tacc, input logic taccum, input logic [3:0] twa);
        logic [31:0] exp;
        int          n;
        int          busy_gaps;
        exp = model(ta, tb, tacc, taccum);
        @(negedge clk);
        a = ta; b = tb; acc = tacc; accumulate = taccum; wa_in = twa; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; acc = $urandom; accumulate = 1'($urandom); wa_in = 4'($urandom);
        chk({tag, ".busy_on_accept"}, {31'd0, busy}, 32'd1);
        n = 0;
        busy_gaps = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (!busy) busy_gaps++;
        end
        chk({tag, ".latency"}, n, 33);
        chk({tag, ".busy_gaps"}, busy_gaps, 0);
        chk({tag, ".result"}, result, exp);
        chk({tag, ".wa_out"}, {28'd0, wa_out}, {28'd0, twa});
        chk({tag, ".flag_n"}, {31'd0, flag_n}, {31'd0, exp[31]});
        chk({tag, ".flag_z"}, {31'd0, flag_z}, {31'd0, (exp == 32'd0)});
        @(posedge clk);
        #1;
        chk({tag, ".done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, ".result_held"}, result, exp);
    endtask

    initial begin
        logic [31:0] ra, rb, racc, exp2;
        int          done_cnt, first_done, second_done, busy_bad, extra_done;
        logic        exp_busy;

        reset = 1'b1; start = 1'b0; a = '0; b = '0; acc = '0; accumulate = 1'b0; wa_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.result", result, 32'd0);
        chk("reset.wa_out", {28'd0, wa_out}, 32'd0);
        chk("reset.flag_n", {31'd0, flag_n}, 32'd0);
        chk("reset.flag_z", {31'd0, flag_z}, 32'd0);
        reset = 1'b0;

        run_op("mul3x5", 32'd3, 32'd5, 32'd0, 1'b0, 4'd9);
        chk("mul3x5.value", result, 32'd15);
        run_op("wrap_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd3);
        chk("wrap_ff.value", result, 32'd1);
        run_op("wrap_80", 32'h8000_0000, 32'd2, 32'd0, 1'b0, 4'd15);
        chk("wrap_80.flag_z", {31'd0, flag_z}, 32'd1);
        run_op("mla", 32'd7, 32'd6, 32'd100, 1'b1, 4'd4);
`ifdef MUL_UNIT_MLA_EN
        chk("mla.value", result, 32'd142);
`else
        chk("mla.value", result, 32'd42);
`endif
        run_op("bzero", 32'h1234_5678, 32'd0, 32'd0, 1'b0, 4'd6);
        run_op("negres", 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 4'd1);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; racc = $urandom;
            run_op($sformatf("rand%0d", i), ra, rb, racc, 1'($urandom), 4'($urandom));
        end

        // Start held high for 40 edges: accepted at edges 0 and 34 only.
        ra = $urandom; rb = $urandom;
        exp2 = model(ra, rb, 32'd0, 1'b0);
        @(negedge clk);
        a = ra; b = rb; acc = 32'd0; accumulate = 1'b0; wa_in = 4'd11; start = 1'b1;
        done_cnt = 0; first_done = -1; second_done = -1; busy_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (i == 39) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
            exp_busy = (i < 33) || (i >= 34 && i < 67);
            if (busy !== exp_busy) busy_bad++;
        end
        chk("held.done_count", done_cnt, 2);
        chk("held.first_done", first_done, 33);
        chk("held.second_done", second_done, 67);
        chk("held.busy_pattern", busy_bad, 0);
        chk("held.result", result, exp2);

        // Reset abandons an operation ten cycles into BUSY.
        @(negedge clk);
        a = 32'd9; b = 32'd9; wa_in = 4'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.result", result, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        chk("abort.no_done", extra_done, 0);
        run_op("after_abort", 32'd11, 32'd13, 32'd0, 1'b0, 4'd7);
        chk("after_abort.value", result, 32'd143);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port start, input, 1 bit: request a new multiply; accepted only in IDLE.
REQ-004 SHALL have port a, input, 32 bits: multiplicand (register read port 1 value).
REQ-005 SHALL have port b, input, 32 bits: multiplier (register read port 2 value).
REQ-006 SHALL have port acc, input, 32 bits: accumulate addend (MLA Ra value).
REQ-007 SHALL have port accumulate, input, 1 bit: 1 = MLA, 0 = MUL.
REQ-008 SHALL have port wa_in, input, 4 bits: destination register index.
REQ-009 SHALL have port busy, output, 1 bit: high in BUSY and DONE states.
REQ-010 SHALL have port done, output, 1 bit: one-cycle result-valid pulse; drives register-file write enable.
REQ-011 SHALL have port result, output, 32 bits: low 32 bits of the product (plus addend); drives register-file write data.
REQ-012 SHALL have port wa_out, output, 4 bits: latched destination index; drives register-file write address.
REQ-013 SHALL have port flag_n, output, 1 bit, and port flag_z, output, 1 bit: result[31] and (result == 0).

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL, in IDLE with start=1 at a posedge, latch a, b, wa_in, and accumulate; set product to acc if accumulate=1, else 0; clear 5-bit counter; go to BUSY.
REQ-016 SHALL, in each BUSY cycle, add the multiplicand register to product when the multiplier register LSB is 1, then shift the multiplicand left 1 and the multiplier right 1, all modulo 2^32.
REQ-017 SHALL stay in BUSY for exactly 32 posedges, leaving when the counter wraps from 31 to 0, then enter DONE.
REQ-018 SHALL assert done for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-019 SHALL set latency to 33 cycles: start accepted at edge k -> done high between edges k+33 and k+34.
REQ-020 SHALL ignore start in BUSY and DONE without queueing it; start in the cycle after DONE (IDLE) is accepted normally.
REQ-021 SHALL hold result, wa_out, flag_n, and flag_z stable from DONE until the next DONE; inputs changing during BUSY have no effect.
REQ-022 SHALL discard overflow beyond bit 31 and treat all operands as unsigned; the low 32 bits match the signed result.

Reset
REQ-023 SHALL, with reset high at a posedge, force IDLE, busy=0, done=0, result=0, wa_out=0, flag_n=0, flag_z=0, counter=0, from any state.
REQ-024 SHALL have reset take priority over start; an operation in flight is abandoned and no done pulse is produced for it.

Configuration
REQ-025 SHALL compile MLA support in when macro MUL_UNIT_MLA_EN is defined: accumulate and acc behave per REQ-015.
REQ-026 SHALL, without MUL_UNIT_MLA_EN, keep the acc and accumulate ports present but ignore them; product always starts at 0.

Verification
REQ-027 SHALL cover MUL: a=3, b=5, start one cycle -> done pulse at edge k+33, result=15, flag_n=0, flag_z=0, wa_out=wa_in.
REQ-028 SHALL cover wrap: a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0x00000001; a=0x80000000, b=2 -> result=0, flag_z=1.
REQ-029 SHALL cover MLA with MUL_UNIT_MLA_EN: a=7, b=6, acc=100, accumulate=1 -> result=142; the same stimulus without the macro -> result=42.
REQ-030 SHALL cover start held high for 40 cycles -> exactly one done per 34 cycles, busy continuous during each operation, no extra done.
REQ-031 SHALL cover reset asserted at BUSY cycle 10 -> next cycle busy=0, result=0, no done; a new start then completes normally.
REQ-032 SHALL cover b=0 with a=0x12345678 -> result=0, flag_z=1, latency still 33.
